// File: rtl/cpu0_mem_arbiter_if.sv
// Bus bundle between the cpu0 request stages, the arbiter and the shared memory port.
// slave = arbiter side, master = requesters plus memory.
interface cpu0_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_rw;
    logic [31:0] mar;
    logic [31:0] mdr;
    logic [31:0] dbus;
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_rw, d_addr, d_wdata, dbus,
        output if_ack, if_rdata, d_ack, d_rdata, m_en, m_rw, mar, mdr, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_rw, d_addr, d_wdata, dbus,
        input  if_ack, if_rdata, d_ack, d_rdata, m_en, m_rw, mar, mdr, busy
    );
endinterface

// File: rtl/cpu0_mem_arbiter.sv
// Shares the single cpu0 memory port between instruction fetch and load/store.
// Each grant runs IDLE -> ISSUE -> COMPLETE; data wins unless fetch has waited MAX_DATA_RUN grants.
module cpu0_mem_arbiter #(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic                clock,
    input  logic                reset,
    cpu0_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

    state_t      state, state_nxt;
    logic        win_fetch;
    logic [3:0]  run_cnt;
    logic        m_en, m_rw, if_ack, d_ack;
    logic [31:0] mar, mdr, if_rdata, d_rdata;
    logic        any_req, fetch_win;

    assign any_req   = bus.if_req | bus.d_req;
    // Fetch takes the port when data is idle or data has hogged it for a full run.
    assign fetch_win = bus.if_req & (~bus.d_req | (run_cnt == RUN_MAX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_req) state_nxt = ISSUE;
            ISSUE:    state_nxt = COMPLETE;
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_en      <= 1'b0;
            m_rw      <= 1'b1;
            mar       <= '0;
            mdr       <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            run_cnt   <= '0;
            win_fetch <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    m_en      <= 1'b1;
                    win_fetch <= fetch_win;
                    if (fetch_win) begin
                        mar     <= bus.if_addr;
                        m_rw    <= 1'b1;
                        run_cnt <= '0;
                    end else begin
                        mar  <= bus.d_addr;
                        m_rw <= bus.d_rw;
                        if (!bus.d_rw) mdr <= bus.d_wdata;
                        // Only count data grants that actually made a fetch wait.
                        if (bus.if_req)
                            run_cnt <= (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 4'd1;
                        else
                            run_cnt <= '0;
                    end
                end
                ISSUE: begin
                    m_en <= 1'b0;
                    if (win_fetch) begin
                        if_ack <= 1'b1;
                        if (m_rw) if_rdata <= bus.dbus;
                    end else begin
                        d_ack <= 1'b1;
                        if (m_rw) d_rdata <= bus.dbus;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.m_en     = m_en;
    assign bus.m_rw     = m_rw;
    assign bus.mar      = mar;
    assign bus.mdr      = mdr;
    assign bus.if_ack   = if_ack;
    assign bus.d_ack    = d_ack;
    assign bus.if_rdata = if_rdata;
    assign bus.d_rdata  = d_rdata;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// Directed and randomized bench for cpu0_mem_arbiter against a transaction-level model.
module tb_cpu0_mem_arbiter;

    localparam int MAX_RUN = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cpu0_mem_arbiter_if bus();

    cpu0_mem_arbiter #(.MAX_DATA_RUN(MAX_RUN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory device: 64 bytes, big-endian words, combinational read, write on the ISSUE edge.
    logic [7:0] mem [0:63];
    int         rd_base;
    assign rd_base  = int'(bus.mar[5:2]) * 4;
    assign bus.dbus = (bus.m_en && bus.m_rw) ?
        {mem[rd_base], mem[rd_base+1], mem[rd_base+2], mem[rd_base+3]} : 32'h0;

    always @(posedge clock) begin
        if (bus.m_en && !bus.m_rw) begin
            mem[rd_base]   <= bus.mdr[31:24];
            mem[rd_base+1] <= bus.mdr[23:16];
            mem[rd_base+2] <= bus.mdr[15:8];
            mem[rd_base+3] <= bus.mdr[7:0];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [16];
    int          run;
    logic [31:0] exp_mdr, exp_if, exp_d;
    int          checks = 0;
    int          errors = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] w);
        ref_mem[idx]   = w;
        mem[idx*4]     = w[31:24];
        mem[idx*4+1]   = w[23:16];
        mem[idx*4+2]   = w[15:8];
        mem[idx*4+3]   = w[7:0];
    endtask

    task automatic model_reset();
        run = 0; exp_mdr = '0; exp_if = '0; exp_d = '0;
    endtask

    // One full access from the IDLE sample to the end of COMPLETE, predicted from the arbitration rules.
    task automatic step_access(output bit was_fetch);
        bit          fw;
        logic        rw;
        logic [31:0] a, rd;
        int          idx;
        fw  = bus.if_req && (!bus.d_req || run == MAX_RUN);
        a   = fw ? bus.if_addr : bus.d_addr;
        rw  = fw ? 1'b1 : bus.d_rw;
        idx = int'(a[5:2]);
        rd  = ref_mem[idx];
        if (!rw) begin
            exp_mdr      = bus.d_wdata;
            ref_mem[idx] = bus.d_wdata;
        end else if (fw) exp_if = rd;
        else             exp_d  = rd;
        if (fw)              run = 0;
        else if (bus.if_req) run = (run < MAX_RUN) ? run + 1 : MAX_RUN;
        else                 run = 0;

        @(posedge clock); #1;
        check32("issue_m_en", 32'(bus.m_en), 32'd1);
        check32("issue_mar", bus.mar, a);
        check32("issue_m_rw", 32'(bus.m_rw), 32'(rw));
        check32("issue_mdr", bus.mdr, exp_mdr);
        check32("issue_busy", 32'(bus.busy), 32'd1);
        check32("issue_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);

        @(posedge clock); #1;
        check32("cmpl_m_en", 32'(bus.m_en), 32'd0);
        check32("cmpl_if_ack", 32'(bus.if_ack), 32'(fw));
        check32("cmpl_d_ack", 32'(bus.d_ack), 32'(!fw));
        check32("cmpl_if_rdata", bus.if_rdata, exp_if);
        check32("cmpl_d_rdata", bus.d_rdata, exp_d);
        check32("cmpl_busy", 32'(bus.busy), 32'd1);

        @(posedge clock); #1;
        check32("idle_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        check32("idle_busy", 32'(bus.busy), 32'd0);
        was_fetch = fw;
    endtask

    task automatic new_fetch();
        bus.if_req  = ($urandom_range(0, 3) != 0);
        bus.if_addr = {26'd0, 4'($urandom), 2'b00};
    endtask

    task automatic new_data();
        bus.d_req   = ($urandom_range(0, 3) != 0);
        bus.d_rw    = 1'($urandom);
        bus.d_addr  = {26'd0, 4'($urandom), 2'b00};
        bus.d_wdata = $urandom;
    endtask

    initial begin
        bit       wf;
        bit [5:0] order;

        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_rw = 1; bus.d_addr = 0; bus.d_wdata = 0;
        for (int i = 0; i < 16; i++) poke(i, $urandom);
        poke(0, 32'h001F0018);
        poke(7, 32'h00000001);
        model_reset();

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        check32("rst_m_en", 32'(bus.m_en), 32'd0);
        check32("rst_m_rw", 32'(bus.m_rw), 32'd1);
        check32("rst_mar", bus.mar, 32'd0);
        check32("rst_mdr", bus.mdr, 32'd0);
        check32("rst_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        check32("rst_if_rdata", bus.if_rdata, 32'd0);
        check32("rst_d_rdata", bus.d_rdata, 32'd0);
        check32("rst_busy", 32'(bus.busy), 32'd0);
        reset = 0;
        @(posedge clock); #1;
        check32("idle_no_req_m_en", 32'(bus.m_en), 32'd0);

        // Fetch only
        bus.if_req = 1; bus.if_addr = 32'h0;
        step_access(wf);
        check32("fetch_winner", 32'(wf), 32'd1);
        check32("fetch_word", bus.if_rdata, 32'h001F0018);
        bus.if_req = 0;

        // Store then load
        bus.d_req = 1; bus.d_rw = 0; bus.d_addr = 32'h20; bus.d_wdata = 32'h2A;
        step_access(wf);
        bus.d_rw = 1;
        step_access(wf);
        check32("load_back", bus.d_rdata, 32'h2A);
        check32("if_rdata_kept", bus.if_rdata, 32'h001F0018);
        bus.d_req = 0;

        // Simultaneous: data first, fetch on the following IDLE
        bus.if_req = 1; bus.if_addr = 32'h0;
        bus.d_req = 1; bus.d_rw = 1; bus.d_addr = 32'h1C;
        step_access(wf);
        check32("simul_first_data", 32'(wf), 32'd0);
        check32("simul_d_rdata", bus.d_rdata, 32'h1);
        bus.d_req = 0;
        step_access(wf);
        check32("simul_then_fetch", 32'(wf), 32'd1);

        // Starvation guard: grant order D D D D F D
        bus.if_req = 1; bus.if_addr = 32'h4;
        bus.d_req = 1; bus.d_rw = 1;
        for (int i = 0; i < 6; i++) begin
            bus.d_addr = {26'd0, 4'($urandom), 2'b00};
            step_access(wf);
            order[i] = wf;
            if (wf) bus.if_addr = 32'h8;
        end
        check32("grant_order", {26'd0, order}, 32'h10);
        bus.d_req = 0;

        // Reset during ISSUE of a fetch
        bus.if_req = 1; bus.if_addr = 32'h10;
        @(posedge clock); #1;
        check32("pre_rst_m_en", 32'(bus.m_en), 32'd1);
        reset = 1; #1;
        check32("midrst_m_en", 32'(bus.m_en), 32'd0);
        check32("midrst_busy", 32'(bus.busy), 32'd0);
        check32("midrst_mar", bus.mar, 32'd0);
        @(posedge clock); #1;
        check32("midrst_no_ack", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        reset = 0;
        model_reset();
        step_access(wf);
        check32("post_rst_fetch", 32'(wf), 32'd1);

        // Randomized traffic
        new_fetch(); new_data();
        for (int n = 0; n < 60; n++) begin
            while (!bus.if_req && !bus.d_req) begin
                @(posedge clock); #1;
                check32("idle_m_en", 32'(bus.m_en), 32'd0);
                check32("idle_busy_r", 32'(bus.busy), 32'd0);
                new_fetch(); new_data();
            end
            step_access(wf);
            if (wf) new_fetch();
            else    new_data();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
